// File: rtl/conv_enc_block_sched_if.sv
// Bundle of descriptor, encoder-control, subblock-FIFO and output-stream signals
// shared by the block scheduler (master) and its surrounding logic (slave).
interface conv_enc_block_sched_if;
    logic       desc_valid;
    logic       desc_ready;
    logic       desc_len;
    logic [7:0] desc_tail;
    logic       data_valid;
    logic       code_block_length;
    logic [7:0] tail_byte;
    logic       computation_done;
    logic       rdreq_subblock;
    logic [7:0] q0;
    logic [7:0] q1;
    logic [7:0] q2;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [1:0] out_stream;
    logic       out_last;
    logic       busy;
    logic       timeout_err;

    modport master (
        input  desc_valid, desc_len, desc_tail, computation_done, q0, q1, q2, out_ready,
        output desc_ready, data_valid, code_block_length, tail_byte, rdreq_subblock,
               out_valid, out_data, out_stream, out_last, busy, timeout_err
    );

    modport slave (
        output desc_valid, desc_len, desc_tail, computation_done, q0, q1, q2, out_ready,
        input  desc_ready, data_valid, code_block_length, tail_byte, rdreq_subblock,
               out_valid, out_data, out_stream, out_last, busy, timeout_err
    );
endinterface

// File: rtl/conv_enc_block_sched.sv
// Runs the convolutional encoder one code block at a time and drains its three
// subblock FIFOs as a single interleaved q0,q1,q2 ready/valid byte stream.
module conv_enc_block_sched #(
    parameter int unsigned SHORT_BYTES  = 132,
    parameter int unsigned LONG_BYTES   = 768,
    parameter int unsigned DONE_TIMEOUT = 20000
) (
    input  logic                    clk,
    input  logic                    reset,
    conv_enc_block_sched_if.master  io_sched
);
    localparam int unsigned CW = $clog2(LONG_BYTES);
    localparam int unsigned WW = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT) : 1;
    localparam logic [CW-1:0] SHORT_LAST = CW'(SHORT_BYTES - 1);
    localparam logic [CW-1:0] LONG_LAST  = CW'(LONG_BYTES - 1);
    localparam logic [WW-1:0] WD_LAST    = WW'(DONE_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LAUNCH, S_WAIT_DONE, S_READ, S_CAPTURE, S_EMIT0, S_EMIT1, S_EMIT2
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic          r_len;
    logic [7:0]    r_tail;
    logic [CW-1:0] r_cnt;
    logic [WW-1:0] r_wdog;
    logic          r_err;
    logic [7:0]    r_b0;
    logic [7:0]    r_b1;
    logic [7:0]    r_b2;
    logic          w_last_byte;
    logic          w_expire;

    assign w_last_byte = (r_cnt == (r_len ? LONG_LAST : SHORT_LAST));
    assign w_expire    = (DONE_TIMEOUT != 0) && (r_wdog == WD_LAST);

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:      if (io_sched.desc_valid) w_next = S_LAUNCH;
            S_LAUNCH:    w_next = S_WAIT_DONE;
            // done takes priority over a watchdog expiry in the same cycle
            S_WAIT_DONE: if (io_sched.computation_done) w_next = S_READ;
                         else if (w_expire)             w_next = S_IDLE;
            S_READ:      w_next = S_CAPTURE;
            S_CAPTURE:   w_next = S_EMIT0;
            S_EMIT0:     if (io_sched.out_ready) w_next = S_EMIT1;
            S_EMIT1:     if (io_sched.out_ready) w_next = S_EMIT2;
            S_EMIT2:     if (io_sched.out_ready) w_next = w_last_byte ? S_IDLE : S_READ;
            default:     w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_len  <= 1'b0;
            r_tail <= '0;
            r_cnt  <= '0;
            r_wdog <= '0;
            r_err  <= 1'b0;
            r_b0   <= '0;
            r_b1   <= '0;
            r_b2   <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (io_sched.desc_valid) begin
                    r_len  <= io_sched.desc_len;
                    r_tail <= io_sched.desc_tail;
                end
                S_LAUNCH: begin
                    r_wdog <= '0;
                    r_cnt  <= '0;
                end
                S_WAIT_DONE: if (!io_sched.computation_done) begin
                    if (w_expire) r_err  <= 1'b1;
                    else          r_wdog <= r_wdog + 1'b1;
                end
                S_CAPTURE: begin
                    r_b0 <= io_sched.q0;
                    r_b1 <= io_sched.q1;
                    r_b2 <= io_sched.q2;
                end
                S_EMIT2: if (io_sched.out_ready) r_cnt <= w_last_byte ? '0 : r_cnt + 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        io_sched.desc_ready     = (r_state == S_IDLE);
        io_sched.data_valid     = (r_state == S_LAUNCH);
        io_sched.rdreq_subblock = (r_state == S_READ);
        io_sched.busy           = (r_state != S_IDLE);
        io_sched.out_valid      = 1'b0;
        io_sched.out_data       = '0;
        io_sched.out_stream     = 2'd0;
        io_sched.out_last       = 1'b0;
        case (r_state)
            S_EMIT0: begin
                io_sched.out_valid  = 1'b1;
                io_sched.out_data   = r_b0;
                io_sched.out_stream = 2'd0;
            end
            S_EMIT1: begin
                io_sched.out_valid  = 1'b1;
                io_sched.out_data   = r_b1;
                io_sched.out_stream = 2'd1;
            end
            S_EMIT2: begin
                io_sched.out_valid  = 1'b1;
                io_sched.out_data   = r_b2;
                io_sched.out_stream = 2'd2;
                io_sched.out_last   = w_last_byte;
            end
            default: ;
        endcase
    end

    assign io_sched.code_block_length = r_len;
    assign io_sched.tail_byte         = r_tail;
    assign io_sched.timeout_err       = r_err;
endmodule

// File: tb/tb_conv_enc_block_sched.sv
// Scoreboard bench: an encoder/FIFO model pushes expected bytes at launch and the
// output monitor pops and compares them on every stream handshake.
module tb_conv_enc_block_sched;
    localparam int unsigned SHORT_N = 132;
    localparam int unsigned LONG_N  = 768;
    localparam int unsigned TMO     = 16;

    typedef struct packed { logic [7:0] data; logic [1:0] stream; logic last; } exp_t;
    typedef struct packed { logic len; logic [7:0] tail; } desc_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic done_main = 1'b0;
    logic done_enc = 1'b0;
    always #5 clk = ~clk;

    conv_enc_block_sched_if bus();
    assign bus.computation_done = done_main | done_enc;

    conv_enc_block_sched #(
        .SHORT_BYTES (SHORT_N),
        .LONG_BYTES  (LONG_N),
        .DONE_TIMEOUT(TMO)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .io_sched(bus)
    );

    exp_t        sb[$];
    desc_t       desc_q[$];
    logic [7:0]  f0[$], f1[$], f2[$];
    int unsigned n_chk = 0, n_fail = 0;
    int unsigned rd_total = 0, hs_total = 0, hs_blk = 0, dv_total = 0;
    int unsigned enc_delay = 3, ready_mode = 0;
    bit          enc_hang = 0, b2b_chk = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Encoder model: on launch, check descriptor, fill FIFOs and scoreboard, then raise done.
    initial forever begin
        @(negedge clk);
        if (!reset && bus.data_valid) begin
            desc_t d;
            int unsigned n;
            logic [7:0] b0, b1, b2;
            dv_total++;
            hs_blk = 0;
            chk("desc_pending", desc_q.size() != 0, 1);
            d = (desc_q.size() != 0) ? desc_q.pop_front() : '0;
            chk("launch_len", bus.code_block_length, d.len);
            chk("launch_tail", bus.tail_byte, d.tail);
            if (!enc_hang) begin
                n = d.len ? LONG_N : SHORT_N;
                for (int unsigned i = 0; i < n; i++) begin
                    b0 = 8'($urandom_range(0, 255));
                    b1 = 8'($urandom_range(0, 255));
                    b2 = 8'($urandom_range(0, 255));
                    f0.push_back(b0); f1.push_back(b1); f2.push_back(b2);
                    sb.push_back('{data: b0, stream: 2'd0, last: 1'b0});
                    sb.push_back('{data: b1, stream: 2'd1, last: 1'b0});
                    sb.push_back('{data: b2, stream: 2'd2, last: (i == n - 1)});
                end
                repeat (enc_delay) @(posedge clk);
                #1 done_enc = 1'b1;
                @(posedge clk);
                #1 done_enc = 1'b0;
            end
        end
    end

    // Subblock FIFO model: data appears the cycle after the read strobe.
    initial begin
        bus.q0 = '0; bus.q1 = '0; bus.q2 = '0;
        forever begin
            @(negedge clk);
            if (!reset && bus.rdreq_subblock) begin
                rd_total++;
                chk("fifo_nonempty", f0.size() != 0, 1);
                @(posedge clk);
                #1;
                if (f0.size() != 0) begin
                    bus.q0 = f0.pop_front();
                    bus.q1 = f1.pop_front();
                    bus.q2 = f2.pop_front();
                end
            end
        end
    end

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1 bus.out_ready = (ready_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Output monitor: scoreboard compare, stall stability, launch/accept ordering.
    initial begin
        bit         prev_stall, prev_last_hs;
        logic [7:0] prev_data;
        logic [1:0] prev_stream;
        logic       prev_cbl;
        exp_t       e;
        prev_stall = 0; prev_last_hs = 0; prev_data = '0; prev_stream = '0; prev_cbl = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_stall = 0;
                prev_last_hs = 0;
                prev_cbl = bus.code_block_length;
            end else begin
                if (prev_stall) begin
                    chk("stall_valid", bus.out_valid, 1);
                    chk("stall_data", bus.out_data, prev_data);
                    chk("stall_stream", bus.out_stream, prev_stream);
                end
                if (bus.code_block_length !== prev_cbl) chk("cbl_change_at_launch", bus.data_valid, 1);
                if (b2b_chk && bus.desc_valid && bus.desc_ready) chk("b2b_accept_after_last", prev_last_hs, 1);
                if (bus.out_valid && bus.out_ready) begin
                    hs_total++;
                    hs_blk++;
                    chk("sb_nonempty", sb.size() != 0, 1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        chk("out_data", bus.out_data, e.data);
                        chk("out_stream", bus.out_stream, e.stream);
                        chk("out_last", bus.out_last, e.last);
                    end
                end
                prev_stall   = bus.out_valid && !bus.out_ready;
                prev_data    = bus.out_data;
                prev_stream  = bus.out_stream;
                prev_last_hs = bus.out_valid && bus.out_ready && bus.out_last;
                prev_cbl     = bus.code_block_length;
            end
        end
    end

    // Must be called just after a rising edge.
    task automatic send_desc(input logic len, input logic [7:0] tail);
        int unsigned k = 0;
        desc_t d;
        bus.desc_valid = 1'b1;
        bus.desc_len   = len;
        bus.desc_tail  = tail;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.desc_ready && k < 20000);
        chk("desc_accept", bus.desc_ready, 1);
        d.len = len;
        d.tail = tail;
        desc_q.push_back(d);
        @(posedge clk);
        #1 bus.desc_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int unsigned k = 0;
        do begin
            @(negedge clk);
            k++;
        end while ((bus.busy || sb.size() != 0) && k < 30000);
        chk("idle_reached", !bus.busy && sb.size() == 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic run_block(input logic len, input logic [7:0] tail);
        int unsigned r0, h0, d0, n;
        r0 = rd_total; h0 = hs_total; d0 = dv_total;
        n = len ? LONG_N : SHORT_N;
        send_desc(len, tail);
        wait_idle();
        chk("launch_pulses", dv_total - d0, 1);
        chk("rdreq_count", rd_total - r0, n);
        chk("byte_count", hs_total - h0, 3 * n);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_desc_ready"}, bus.desc_ready, 1);
        chk({tag, "_data_valid"}, bus.data_valid, 0);
        chk({tag, "_cbl"}, bus.code_block_length, 0);
        chk({tag, "_tail"}, bus.tail_byte, 0);
        chk({tag, "_rdreq"}, bus.rdreq_subblock, 0);
        chk({tag, "_out_valid"}, bus.out_valid, 0);
        chk({tag, "_out_data"}, bus.out_data, 0);
        chk({tag, "_out_stream"}, bus.out_stream, 0);
        chk({tag, "_out_last"}, bus.out_last, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_timeout_err"}, bus.timeout_err, 0);
    endtask

    initial begin
        int unsigned k, r0;
        bus.desc_valid = 1'b0;
        bus.desc_len   = 1'b0;
        bus.desc_tail  = '0;

        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst");
        @(posedge clk);
        #1 reset = 1'b0;

        // computation_done in IDLE must not start anything
        r0 = rd_total;
        done_main = 1'b1;
        @(posedge clk);
        #1 done_main = 1'b0;
        @(negedge clk);
        chk("done_in_idle_busy", bus.busy, 0);
        chk("done_in_idle_rdreq", rd_total - r0, 0);
        @(posedge clk);
        #1;

        // Short block; done lands on the last watchdog cycle and must win
        ready_mode = 0;
        enc_delay = TMO;
        run_block(1'b0, 8'hA5);
        chk("no_timeout_on_done_at_expiry", bus.timeout_err, 0);

        // Long block with random backpressure
        ready_mode = 1;
        enc_delay = 3;
        run_block(1'b1, 8'h5A);

        // Back-to-back short then long
        ready_mode = 0;
        r0 = rd_total;
        send_desc(1'b0, 8'h11);
        b2b_chk = 1;
        send_desc(1'b1, 8'h22);
        wait_idle();
        b2b_chk = 0;
        chk("b2b_rdreq_total", rd_total - r0, SHORT_N + LONG_N);

        // Watchdog abort: done never arrives
        enc_hang = 1;
        r0 = rd_total;
        send_desc(1'b0, 8'h77);
        @(negedge clk);
        chk("wd_launch", bus.data_valid, 1);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.timeout_err && k < 40);
        chk("wd_abort_cycle", k, TMO + 1);
        chk("wd_idle", bus.busy, 0);
        chk("wd_no_rdreq", rd_total - r0, 0);
        @(posedge clk);
        #1 enc_hang = 0;
        run_block(1'b0, 8'h99);
        chk("timeout_err_sticky", bus.timeout_err, 1);

        // Reset during EMIT1 of byte 50
        send_desc(1'b0, 8'h3C);
        k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (!(bus.out_valid && bus.out_stream == 2'd1 && hs_blk == 151) && k < 5000);
        chk("reach_emit1_byte50", bus.out_valid && bus.out_stream == 2'd1 && hs_blk == 151, 1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("midrst");
        sb.delete(); f0.delete(); f1.delete(); f2.delete(); desc_q.delete();
        @(posedge clk);
        #1 reset = 1'b0;
        run_block(1'b0, 8'hC3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete, failures so far %0d", n_fail);
        $fatal(1);
    end
endmodule
